// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU op codes, forwarding selects, mul/div FSM states.
// Also imported by the decoder and the forwarding unit so the encodings cannot drift apart.
package ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_MULT  = 4'd8,
    ALU_MULTU = 4'd9,
    ALU_DIV   = 4'd10,
    ALU_DIVU  = 4'd11,
    ALU_MFHI  = 4'd12,
    ALU_MFLO  = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_WB      = 2'b01,
    FWD_EXMEM   = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_md_op(input logic [3:0] op);
    return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
  endfunction

endpackage

// File: rtl/ex_stage_mul_div.sv
// Iterative multiply/divide engine: start latches operands, HI/LO written after MD_CYCLES busy cycles.
// abort returns to IDLE at once and leaves HI/LO untouched.
module mul_div_unit
  import ex_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;

  logic signed [2*DATA_W-1:0] sprod;
  logic        [2*DATA_W-1:0] uprod;
  logic signed [DATA_W-1:0]   squot, srem;
  logic        [DATA_W-1:0]   uquot, urem, res_hi, res_lo;

  always_comb begin
    sprod = $signed({{DATA_W{a_q[DATA_W-1]}}, a_q}) * $signed({{DATA_W{b_q[DATA_W-1]}}, b_q});
    uprod = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    squot = $signed(a_q) / $signed(b_q);
    srem  = $signed(a_q) % $signed(b_q);
    uquot = a_q / b_q;
    urem  = a_q % b_q;
    res_hi = '0;
    res_lo = '0;
    case (op_q)
      ALU_MULT:  {res_hi, res_lo} = sprod;
      ALU_MULTU: {res_hi, res_lo} = uprod;
      ALU_DIV:   begin res_hi = srem; res_lo = squot; end
      ALU_DIVU:  begin res_hi = urem; res_lo = uquot; end
      default:   ;
    endcase
    // Divide by zero: quotient saturates to all ones, remainder is the dividend.
    if ((op_q == ALU_DIV || op_q == ALU_DIVU) && b_q == '0) begin
      res_hi = a_q;
      res_lo = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (abort) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          state_d = MD_BUSY;
        end
        MD_BUSY: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MD_CYCLES - 1)) begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            state_d = MD_DONE;
          end
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == MD_BUSY);
  assign done = (state_q == MD_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, EX/MEM register; mul/div ops stall the front end
// for MD_CYCLES+1 cycles while mul_div_unit iterates. Single-cycle ops have 1-cycle latency.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic              id_ex_valid,
  input  logic [DATA_W-1:0] id_ex_rs_data,
  input  logic [DATA_W-1:0] id_ex_rt_data,
  input  logic [DATA_W-1:0] id_ex_imm,
  input  logic              id_ex_alu_src,
  input  logic [3:0]        id_ex_alu_op,
  input  logic [4:0]        id_ex_rd,
  input  logic              id_ex_reg_write,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_mem_write,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_mem_valid,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [DATA_W-1:0] ex_mem_store_data,
  output logic [4:0]        ex_mem_rd,
  output logic              ex_mem_reg_write,
  output logic              ex_mem_mem_read,
  output logic              ex_mem_mem_write
);

  logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_res, md_hi, md_lo;
  logic              md_start, md_busy, md_done;

  logic              valid_q, valid_d, rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;
  logic [DATA_W-1:0] res_q, res_d, st_q, st_d;
  logic [4:0]        rd_q, rd_d;

  always_comb begin
    case (forward_a)
      FWD_EXMEM: fwd_a = res_q;
      FWD_WB:    fwd_a = wb_data;
      default:   fwd_a = id_ex_rs_data;
    endcase
    case (forward_b)
      FWD_EXMEM: fwd_b = res_q;
      FWD_WB:    fwd_b = wb_data;
      default:   fwd_b = id_ex_rt_data;
    endcase
    alu_b = id_ex_alu_src ? id_ex_imm : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    case (id_ex_alu_op)
      ALU_ADD:  alu_res = fwd_a + alu_b;
      ALU_SUB:  alu_res = fwd_a - alu_b;
      ALU_AND:  alu_res = fwd_a & alu_b;
      ALU_OR:   alu_res = fwd_a | alu_b;
      ALU_XOR:  alu_res = fwd_a ^ alu_b;
      ALU_NOR:  alu_res = ~(fwd_a | alu_b);
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
      ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, fwd_a < alu_b};
      ALU_MFHI: alu_res = md_hi;
      ALU_MFLO: alu_res = md_lo;
      default:  alu_res = '0;
    endcase
  end

  // Start only from IDLE; the DONE cycle must not retrigger on the op still held in ID/EX.
  assign md_start = id_ex_valid && is_md_op(id_ex_alu_op) && !md_busy && !md_done && !flush;
  assign stall    = rst_n && !flush && (md_start || md_busy);

  mul_div_unit #(
    .DATA_W    (DATA_W),
    .MD_CYCLES (MD_CYCLES)
  ) u_mul_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .abort (flush),
    .op    (id_ex_alu_op),
    .a     (fwd_a),
    .b     (alu_b),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_comb begin
    valid_d = id_ex_valid;
    res_d   = alu_res;
    st_d    = fwd_b;
    rd_d    = id_ex_rd;
    rw_d    = id_ex_reg_write && !md_done;
    mr_d    = id_ex_mem_read;
    mw_d    = id_ex_mem_write;
    if (flush || stall || !id_ex_valid) begin
      valid_d = 1'b0;
      res_d   = '0;
      st_d    = '0;
      rd_d    = '0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      st_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      st_q    <= st_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
    end
  end

  assign ex_mem_valid      = valid_q;
  assign ex_mem_alu_result = res_q;
  assign ex_mem_store_data = st_q;
  assign ex_mem_rd         = rd_q;
  assign ex_mem_reg_write  = rw_q;
  assign ex_mem_mem_read   = mr_q;
  assign ex_mem_mem_write  = mw_q;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning datapath width.
REQ-002 The block SHALL have parameter MD_CYCLES, default 32, meaning iteration count of the multiply/divide engine.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port list, one per line: name  direction  width  meaning.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- flush  in  1  squash instruction in EX
- forward_a  in  2  rs operand select from the forwarding unit
- forward_b  in  2  rt operand select from the forwarding unit
- id_ex_valid  in  1  ID/EX holds a real instruction
- id_ex_rs_data  in  DATA_W  register-file rs value
- id_ex_rt_data  in  DATA_W  register-file rt value
- id_ex_imm  in  DATA_W  extended immediate
- id_ex_alu_src  in  1  1 = operand B is imm
- id_ex_alu_op  in  4  operation code
- id_ex_rd  in  5  destination register
- id_ex_reg_write  in  1  write-back control
- id_ex_mem_read  in  1  memory control
- id_ex_mem_write  in  1  memory control
- wb_data  in  DATA_W  MEM/WB write-back value
- stall  out  1  hold IF/ID/ID-EX
- ex_mem_valid  out  1  EX/MEM register
- ex_mem_alu_result  out  DATA_W  EX/MEM register
- ex_mem_store_data  out  DATA_W  EX/MEM register
- ex_mem_rd  out  5  EX/MEM register
- ex_mem_reg_write  out  1  EX/MEM register
- ex_mem_mem_read  out  1  EX/MEM register
- ex_mem_mem_write  out  1  EX/MEM register

Function
REQ-005 Operand A SHALL be selected by forward_a: 00 gives id_ex_rs_data, 10 gives ex_mem_alu_result, 01 gives wb_data, 11 gives id_ex_rs_data. Operand B SHALL be selected by forward_b using the same encoding.
REQ-006 ex_mem_store_data SHALL be the forwarded B value. The ALU B input SHALL be id_ex_imm when id_ex_alu_src=1, otherwise the forwarded B value.
REQ-007 alu_op encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU
- 8 MULT, 9 MULTU, 10 DIV, 11 DIVU, 12 MFHI, 13 MFLO
- 14 and 15 produce result 0
REQ-008 ADD and SUB SHALL wrap modulo 2^DATA_W with no overflow trap. SLT and SLTU SHALL produce 1 or 0.
REQ-009 Single-cycle ops SHALL be registered into EX/MEM on the next edge, with latency 1 cycle. Control fields SHALL pass through unchanged.
REQ-010 Mul/div FSM states IDLE, BUSY, DONE:
- IDLE: on a valid op 8-11, latch operands, clear the counter, go to BUSY.
- BUSY: the counter increments each cycle; at count MD_CYCLES-1, write HI/LO and go to DONE.
- DONE: go to IDLE unconditionally, with no retrigger on the held op.
REQ-011 stall SHALL equal (IDLE and valid op 8-11) or BUSY. Total stall SHALL be MD_CYCLES+1 cycles.
REQ-012 While stall=1, EX/MEM SHALL load a bubble (valid, reg_write, mem_read and mem_write all 0). In DONE, the op SHALL be registered with reg_write=0.
REQ-013 MULT and MULTU SHALL set {HI,LO} to the 64-bit signed or unsigned product.
REQ-014 DIV and DIVU SHALL set LO to the quotient truncated toward zero and HI to the remainder, which takes the sign of the dividend.
REQ-015 When the divisor is 0, the result SHALL be LO = all ones and HI = dividend.
REQ-016 MFHI and MFLO SHALL read HI/LO as updated; an MFHI in the cycle after DONE SHALL see the new value.
REQ-017 flush SHALL load a bubble into EX/MEM and force the FSM to IDLE with HI/LO unchanged. flush SHALL win over stall and over completion in the same cycle, and stall SHALL be 0 while flush=1.
REQ-018 When id_ex_valid=0, the block SHALL register a bubble and SHALL NOT start the FSM.

Reset
REQ-019 On rst_n=0, asynchronously: all ex_mem_* outputs 0, HI=LO=0, FSM=IDLE, counter=0, stall=0.
REQ-020 Reset mid-BUSY SHALL abandon the operation with no HI/LO write.

Structure
REQ-021 alu_op codes, FSM state encodings and forward-select encodings SHALL live in a shared package/include, also used by the decoder and the forwarding unit.
REQ-022 The iterative engine SHALL be sub-module mul_div_unit, with a start/busy/done handshake and HI/LO outputs. The forwarding muxes, ALU and EX/MEM register SHALL stay in ex_stage.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- forward_a=10, ex_mem_alu_result=5, rs_data=9, op ADD, imm=1, alu_src=1 -> ex_mem_alu_result=6 next cycle.
- MULT A=-3, B=5 -> stall for 33 cycles; then MFLO returns 0xFFFFFFF1 and MFHI returns 0xFFFFFFFF.
- DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
- flush asserted at BUSY count 10 -> stall=0 the same cycle, EX/MEM is a bubble, HI/LO keep their prior values.
- rst_n pulsed low mid-BUSY -> outputs 0 immediately, and the FSM is IDLE after release.
- SUB 0-1 -> 0xFFFFFFFF; SLTU 1,0xFFFFFFFF -> 1; SLT 1,0xFFFFFFFF -> 0.
